// File: rtl/max7219_rx_pkg.sv
// ---------------------------------------------------------------------------
// max7219_pkg
// Shared definitions for the MAX7219 receive-side model: register addresses
// as they appear in bits [11:8] of a 16-bit MAX7219 command word, the state
// type of the commit FSM, and a helper that tells whether an address
// actually writes a register.
// ---------------------------------------------------------------------------
package max7219_pkg;

   localparam logic [3:0] ADDR_NOOP       = 4'h0;
   localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
   localparam logic [3:0] ADDR_DIGIT7     = 4'h8;
   localparam logic [3:0] ADDR_DECODE     = 4'h9;
   localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
   localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
   localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;
   localparam logic [3:0] ADDR_TEST       = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COMMIT = 2'd1,
      ST_DONE   = 2'd2
   } commitState_e;

   // No-op and the two unused addresses 0xD/0xE are accepted by the chip but
   // change nothing, so they produce no write report either.
   function automatic logic isRegWrite(input logic [3:0] addr);
      return !((addr == ADDR_NOOP) || (addr == 4'hD) || (addr == 4'hE));
   endfunction

endpackage

// File: rtl/max7219_rx_if.sv
// ---------------------------------------------------------------------------
// max7219_rx_if
// Bundles everything the receiver reports to the rest of the system.
//   write report : wr_valid, wr_dev[1:0], wr_addr[3:0], wr_data[7:0]
//   read port    : rd_dev[1:0], rd_row[2:0] in; rd_data[7:0] out
//   control view : ctl_intensity, ctl_scan_limit, ctl_decode,
//                  ctl_shutdown_n, ctl_test (all for device rd_dev)
//   status       : frame_done pulse, frame_err sticky flag, err_clr in
// Modport master is taken by max7219_rx, slave by whoever consumes it.
// ---------------------------------------------------------------------------
interface max7219_rx_if;

   logic       wr_valid;
   logic [1:0] wr_dev;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;

   logic [1:0] rd_dev;
   logic [2:0] rd_row;
   logic [7:0] rd_data;

   logic [3:0] ctl_intensity;
   logic [2:0] ctl_scan_limit;
   logic [7:0] ctl_decode;
   logic       ctl_shutdown_n;
   logic       ctl_test;

   logic       frame_done;
   logic       frame_err;
   logic       err_clr;

   modport master (
      output wr_valid, wr_dev, wr_addr, wr_data,
      output rd_data,
      output ctl_intensity, ctl_scan_limit, ctl_decode, ctl_shutdown_n, ctl_test,
      output frame_done, frame_err,
      input  rd_dev, rd_row, err_clr
   );

   modport slave (
      input  wr_valid, wr_dev, wr_addr, wr_data,
      input  rd_data,
      input  ctl_intensity, ctl_scan_limit, ctl_decode, ctl_shutdown_n, ctl_test,
      input  frame_done, frame_err,
      output rd_dev, rd_row, err_clr
   );

endinterface

// File: rtl/max7219_rx_sync.sv
// ---------------------------------------------------------------------------
// max7219_rx_sync
// Brings the three asynchronous MAX7219 pins into the clk domain and derives
// the edge events the receiver needs.
//   clk        in  system clock
//   cs_i       in  chip select pin (active-low)
//   sclk_i     in  serial clock pin
//   data_i     in  serial data pin
//   csSync_o   out synchronised chip select
//   dataSync_o out synchronised data
//   clkRise_o  out one-cycle pulse on a serial clock rising edge
//   csFall_o   out one-cycle pulse on a chip-select falling edge
//   csRise_o   out one-cycle pulse on a chip-select rising edge
// ---------------------------------------------------------------------------
module max7219_rx_sync (
   input  logic clk,
   input  logic cs_i,
   input  logic sclk_i,
   input  logic data_i,
   output logic csSync_o,
   output logic dataSync_o,
   output logic clkRise_o,
   output logic csFall_o,
   output logic csRise_o
);

   logic [2:0] csPipe_q;
   logic [2:0] sclkPipe_q;
   logic [1:0] dataPipe_q;

   // Two flops per pin for metastability, plus a third on cs and sclk so
   // edges can be seen. These flops deliberately keep sampling through
   // reset: when reset drops they already show the true pin levels, so a
   // cs line that is low at that moment is not mistaken for a fresh fall.
   always_ff @(posedge clk) begin
      csPipe_q   <= {csPipe_q[1:0], cs_i};
      sclkPipe_q <= {sclkPipe_q[1:0], sclk_i};
      dataPipe_q <= {dataPipe_q[0], data_i};
   end

   // Edge pulses compare the synchronised level with the one before it.
   always_comb begin
      csSync_o   = csPipe_q[1];
      dataSync_o = dataPipe_q[1];
      clkRise_o  = sclkPipe_q[1] & ~sclkPipe_q[2];
      csFall_o   = ~csPipe_q[1] & csPipe_q[2];
      csRise_o   = csPipe_q[1] & ~csPipe_q[2];
   end

endmodule

// File: rtl/max7219_rx.sv
// ---------------------------------------------------------------------------
// max7219_rx
// Receive-side model of a MAX7219 daisy chain. Shifts in the serial stream,
// latches it on chip-select rise, walks the latched words one device per
// cycle and keeps a shadow of every device's digit and control registers.
// Optional feature: define MAX7219_RX_DTEST_EN to make rd_data show what the
// display would actually light (0xFF in display test, 0x00 in shutdown).
//   clk, rst        system clock, synchronous active-high reset
//   max7219_cs      chip select pin, active-low, asynchronous
//   max7219_clk     serial clock pin, asynchronous
//   max7219_data    serial data pin, MSB first, asynchronous
//   bus             max7219_rx_if.master: write reports, read port,
//                   control view, frame_done / frame_err / err_clr
// ---------------------------------------------------------------------------
module max7219_rx
   import max7219_pkg::*;
#(
   parameter int NUM_DEVICES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         max7219_cs,
   input  logic         max7219_clk,
   input  logic         max7219_data,
   max7219_rx_if.master bus
);

   localparam int SHIFT_W = 16 * NUM_DEVICES;

   logic csSync, dataSync, clkRise, csFall, csRise;

   logic [SHIFT_W-1:0] shift_q;
   logic [SHIFT_W-1:0] snap_q;
   logic [5:0]         bitCnt_q;
   logic               armed_q;
   logic [1:0]         devIdx_q;
   logic               sawDigit7_q;
   logic               frameErr_q;
   logic [7:0]         rdData_q;
   commitState_e       state_q, state_d;

   logic [7:0] digit_q     [NUM_DEVICES][8];
   logic [7:0] decode_q    [NUM_DEVICES];
   logic [3:0] intensity_q [NUM_DEVICES];
   logic [2:0] scanLimit_q [NUM_DEVICES];
   logic       shutdownN_q [NUM_DEVICES];
   logic       test_q      [NUM_DEVICES];

   logic        frameEnd, startCommit, errSet, countShort, countBad;
   logic [15:0] curWord;
   logic [3:0]  curAddr;
   logic [7:0]  curData;
   logic [2:0]  curRow;
   logic        wrValid, frameDone;
   logic        unusedCmdBits;
   logic [7:0]  rawDigit, rdNext, ctlDecode;
   logic [3:0]  ctlIntensity;
   logic [2:0]  ctlScanLimit;
   logic        ctlShutdownN, ctlTest;

   max7219_rx_sync u_sync (
      .clk        (clk),
      .cs_i       (max7219_cs),
      .sclk_i     (max7219_clk),
      .data_i     (max7219_data),
      .csSync_o   (csSync),
      .dataSync_o (dataSync),
      .clkRise_o  (clkRise),
      .csFall_o   (csFall),
      .csRise_o   (csRise)
   );

   // Shift side. Every serial clock rise with cs low pushes one bit in at
   // the bottom. A cs fall restarts the bit count (counting a bit that lands
   // in the very same cycle) and arms the frame check; frames already under
   // way when reset dropped stay unarmed and are ignored at their cs rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q  <= '0;
         bitCnt_q <= 6'd0;
         armed_q  <= 1'b0;
      end else begin
         if (!csSync && clkRise) begin
            shift_q <= {shift_q[SHIFT_W-2:0], dataSync};
         end
         if (csFall) begin
            bitCnt_q <= clkRise ? 6'd1 : 6'd0;
            armed_q  <= 1'b1;
         end else begin
            if (!csSync && clkRise && (bitCnt_q != 6'd63)) begin
               bitCnt_q <= bitCnt_q + 6'd1;
            end
            if (csRise) begin
               armed_q <= 1'b0;
            end
         end
      end
   end

   // Frame checks at cs rise. Fewer than 16 bits latches nothing; any other
   // count that is short or not a multiple of 16 is flagged but still
   // latched, as the silicon would. A rise while a commit is still running
   // is flagged and its data dropped.
   always_comb begin
      countShort  = (bitCnt_q < 6'd16);
      countBad    = (int'(bitCnt_q) < SHIFT_W) || (bitCnt_q[3:0] != 4'd0);
      frameEnd    = csRise && armed_q;
      startCommit = frameEnd && !countShort && (state_q == ST_IDLE);
      errSet      = frameEnd && (countBad || (state_q != ST_IDLE));
   end

   // Snapshot of the chain taken at an accepted latch, so the next frame can
   // start shifting while the commit walks the old one.
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_q <= '0;
      end else if (startCommit) begin
         snap_q <= shift_q;
      end
   end

   // Commit FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Commit FSM next state: one COMMIT cycle per device, then DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (startCommit) state_d = ST_COMMIT;
         ST_COMMIT: if (devIdx_q == 2'(NUM_DEVICES - 1)) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Commit FSM outputs: a write report for each device word that touches a
   // register, and the frame_done pulse when device 0 was given DIGIT7.
   always_comb begin
      wrValid   = 1'b0;
      frameDone = 1'b0;
      case (state_q)
         ST_COMMIT: wrValid   = isRegWrite(curAddr);
         ST_DONE:   frameDone = sawDigit7_q;
         default:   ;
      endcase
   end

   // Word of the device being committed; device k sits in bits [16k+15:16k].
   // The top nibble of a command word means nothing to the MAX7219.
   always_comb begin
      curWord = 16'h0000;
      for (int k = 0; k < NUM_DEVICES; k++) begin
         if (devIdx_q == 2'(k)) begin
            curWord = snap_q[16*k +: 16];
         end
      end
      curAddr = curWord[11:8];
      curData = curWord[7:0];
      curRow  = 3'(curAddr - ADDR_DIGIT0);
   end
   assign unusedCmdBits = ^curWord[15:12];

   // Device index during COMMIT and the DIGIT7-on-device-0 marker.
   always_ff @(posedge clk) begin
      if (rst) begin
         devIdx_q    <= 2'd0;
         sawDigit7_q <= 1'b0;
      end else begin
         if (state_q == ST_COMMIT) begin
            devIdx_q <= devIdx_q + 2'd1;
         end else begin
            devIdx_q <= 2'd0;
         end
         if ((state_q == ST_COMMIT) && (devIdx_q == 2'd0)) begin
            sawDigit7_q <= (curAddr == ADDR_DIGIT7);
         end
      end
   end

   // Shadow register file, written from the commit walk.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_DEVICES; k++) begin
            for (int r = 0; r < 8; r++) begin
               digit_q[k][r] <= 8'h00;
            end
            decode_q[k]    <= 8'h00;
            intensity_q[k] <= 4'h0;
            scanLimit_q[k] <= 3'd0;
            shutdownN_q[k] <= 1'b0;
            test_q[k]      <= 1'b0;
         end
      end else if (wrValid) begin
         for (int k = 0; k < NUM_DEVICES; k++) begin
            if (devIdx_q == 2'(k)) begin
               if ((curAddr >= ADDR_DIGIT0) && (curAddr <= ADDR_DIGIT7)) begin
                  digit_q[k][curRow] <= curData;
               end else begin
                  case (curAddr)
                     ADDR_DECODE:     decode_q[k]    <= curData;
                     ADDR_INTENSITY:  intensity_q[k] <= curData[3:0];
                     ADDR_SCAN_LIMIT: scanLimit_q[k] <= curData[2:0];
                     ADDR_SHUTDOWN:   shutdownN_q[k] <= curData[0];
                     ADDR_TEST:       test_q[k]      <= curData[0];
                     default:         ;
                  endcase
               end
            end
         end
      end
   end

   // Read-side selection by rd_dev; devices beyond the chain read as zero.
   always_comb begin
      rawDigit     = 8'h00;
      ctlDecode    = 8'h00;
      ctlIntensity = 4'h0;
      ctlScanLimit = 3'd0;
      ctlShutdownN = 1'b0;
      ctlTest      = 1'b0;
      for (int k = 0; k < NUM_DEVICES; k++) begin
         if (bus.rd_dev == 2'(k)) begin
            rawDigit     = digit_q[k][bus.rd_row];
            ctlDecode    = decode_q[k];
            ctlIntensity = intensity_q[k];
            ctlScanLimit = scanLimit_q[k];
            ctlShutdownN = shutdownN_q[k];
            ctlTest      = test_q[k];
         end
      end
   end

   // What rd_data will show next cycle. With the display-test view enabled,
   // test mode forces all segments on and beats shutdown, like the chip.
   always_comb begin
`ifdef MAX7219_RX_DTEST_EN
      if (ctlTest) begin
         rdNext = 8'hFF;
      end else if (!ctlShutdownN) begin
         rdNext = 8'h00;
      end else begin
         rdNext = rawDigit;
      end
`else
      rdNext = rawDigit;
`endif
   end

   // Registered read data and the sticky framing error (set beats clear).
   always_ff @(posedge clk) begin
      if (rst) begin
         rdData_q   <= 8'h00;
         frameErr_q <= 1'b0;
      end else begin
         rdData_q <= rdNext;
         if (errSet) begin
            frameErr_q <= 1'b1;
         end else if (bus.err_clr) begin
            frameErr_q <= 1'b0;
         end
      end
   end

   assign bus.wr_valid       = wrValid;
   assign bus.wr_dev         = devIdx_q;
   assign bus.wr_addr        = curAddr;
   assign bus.wr_data        = curData;
   assign bus.rd_data        = rdData_q;
   assign bus.ctl_intensity  = ctlIntensity;
   assign bus.ctl_scan_limit = ctlScanLimit;
   assign bus.ctl_decode     = ctlDecode;
   assign bus.ctl_shutdown_n = ctlShutdownN;
   assign bus.ctl_test       = ctlTest;
   assign bus.frame_done     = frameDone;
   assign bus.frame_err      = frameErr_q;

endmodule
